// File: rtl/masked_subbytes_ctrl_if.sv
// Handshake and data bundle between masked_subbytes_ctrl, its user and its S-box.
// Carries no state and adds no latency.
// The rnd valid/ready pair is the only flow control; start is accepted only when the controller is idle.
interface masked_subbytes_ctrl_if #(
   parameter int SHARES = 2
);
   logic                    StartxSI;
   logic [128*SHARES-1:0]   StatexDI;
   logic                    BusyxSO;
   logic                    DonexSO;
   logic [128*SHARES-1:0]   StatexDO;
   logic                    RndValidxSI;
   logic                    RndReadyxSO;
   logic [8*SHARES-1:0]     SboxInxDO;
   logic [8*SHARES-1:0]     SboxOutxDI;

   // Master: the user plus the S-box, which drive the controller's inputs.
   modport master (
      output StartxSI, StatexDI, RndValidxSI, SboxOutxDI,
      input  BusyxSO, DonexSO, StatexDO, RndReadyxSO, SboxInxDO
   );

   // Slave: the controller itself.
   modport slave (
      input  StartxSI, StatexDI, RndValidxSI, SboxOutxDI,
      output BusyxSO, DonexSO, StatexDO, RndReadyxSO, SboxInxDO
   );
endinterface

// File: rtl/masked_subbytes_ctrl.sv
// Sequences the 16 shared bytes of an AES state through one masked pipelined S-box and collects the results.
// Latency: 17+SBOX_LATENCY cycles from start to done, plus one cycle per randomness bubble.
// Backpressure: a byte issues only when RndValidxSI is high. Define SUBBYTES_IDLE_ZERO_EN to zero the S-box input on non-issue cycles.
module masked_subbytes_ctrl #(
   parameter int SHARES       = 2,
   parameter int SBOX_LATENCY = 4
) (
   input  logic                   ClkxCI,
   input  logic                   RstxBI,
   masked_subbytes_ctrl_if.slave  bus
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FEED  = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   logic [1:0]              state_q, state_d;
   logic [3:0]              issue_cnt_q, issue_cnt_d;
   logic [3:0]              collect_cnt_q, collect_cnt_d;
   logic [SBOX_LATENCY-1:0] tag_q, tag_d;
   logic [128*SHARES-1:0]   in_q, in_d;
   logic [128*SHARES-1:0]   out_q, out_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;

   logic                    active;
   logic                    issue;
   logic                    capture;
   logic [8*SHARES-1:0]     sel_byte;

   assign active  = (state_q == ST_FEED) || (state_q == ST_DRAIN);
   assign issue   = (state_q == ST_FEED) && bus.RndValidxSI;
   // The tag reaching the last stage marks the S-box output as a live result.
   assign capture = active && tag_q[SBOX_LATENCY-1];

   assign bus.RndReadyxSO = issue;
   assign bus.BusyxSO     = busy_q;
   assign bus.DonexSO     = done_q;
   assign bus.StatexDO    = out_q;

   // Gather byte[issue_cnt] of every share; the counter saturates at 15, so no clamp is needed here.
   always_comb begin
      sel_byte = '0;
      for (int s = 0; s < SHARES; s++) begin
         sel_byte[8*s +: 8] = in_q[128*s + {issue_cnt_q, 3'b000} +: 8];
      end
   end

`ifdef SUBBYTES_IDLE_ZERO_EN
   // Keep stale share data out of the S-box whenever no byte is being issued.
   assign bus.SboxInxDO = issue ? sel_byte : '0;
`else
   // Present the current byte at all times; the S-box result is ignored unless tagged.
   assign bus.SboxInxDO = sel_byte;
`endif

   // Next-state logic: FSM, issue/collect counters, tag pipe and result write-back.
   always_comb begin
      state_d       = state_q;
      issue_cnt_d   = issue_cnt_q;
      collect_cnt_d = collect_cnt_q;
      tag_d         = tag_q;
      in_d          = in_q;
      out_d         = out_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.StartxSI) begin
               in_d          = bus.StatexDI;
               issue_cnt_d   = '0;
               collect_cnt_d = '0;
               tag_d         = '0;
               state_d       = ST_FEED;
            end
         end
         ST_FEED, ST_DRAIN: begin
            tag_d[0] = issue;
            for (int i = 1; i < SBOX_LATENCY; i++) begin
               tag_d[i] = tag_q[i-1];
            end
            if (issue) begin
               if (issue_cnt_q == 4'd15) begin
                  state_d = ST_DRAIN;
               end else begin
                  issue_cnt_d = issue_cnt_q + 4'd1;
               end
            end
            if (capture) begin
               for (int s = 0; s < SHARES; s++) begin
                  out_d[128*s + {collect_cnt_q, 3'b000} +: 8] = bus.SboxOutxDI[8*s +: 8];
               end
               if (collect_cnt_q == 4'd15) begin
                  state_d = ST_DONE;
               end else begin
                  collect_cnt_d = collect_cnt_q + 4'd1;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Busy and done are decoded from the next state so they come straight out of flops.
   always_comb begin
      busy_d = (state_d == ST_FEED) || (state_d == ST_DRAIN);
      done_d = (state_d == ST_DONE);
   end

   // State registers with synchronous active-low reset; clearing tags drops any result still inside the S-box.
   always_ff @(posedge ClkxCI) begin
      if (!RstxBI) begin
         state_q       <= ST_IDLE;
         issue_cnt_q   <= '0;
         collect_cnt_q <= '0;
         tag_q         <= '0;
         in_q          <= '0;
         out_q         <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         issue_cnt_q   <= issue_cnt_d;
         collect_cnt_q <= collect_cnt_d;
         tag_q         <= tag_d;
         in_q          <= in_d;
         out_q         <= out_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
      end
   end

endmodule

// File: tb/tb_masked_subbytes_ctrl.sv
// Directed bench for masked_subbytes_ctrl with a behavioural 2-share pipelined S-box.
// The S-box stand-in re-shares each result with a mask derived from its share-1 input.
// Honours SUBBYTES_IDLE_ZERO_EN for the expected S-box input on non-issue cycles.
module tb_masked_subbytes_ctrl;
   localparam int SH = 2;
   localparam int L  = 4;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   logic [127:0] exp_res;   // expected share0^share1 currently held in StatexDO

   masked_subbytes_ctrl_if #(.SHARES(SH)) bus();

   masked_subbytes_ctrl #(.SHARES(SH), .SBOX_LATENCY(L)) dut (
      .ClkxCI (clk),
      .RstxBI (rst_n),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, aa, bb;
      p = 8'h00; aa = a; bb = b;
      for (int i = 0; i < 8; i++) begin
         if (bb[0]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
         bb = bb >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] aes_sbox(input logic [7:0] x);
      logic [7:0] inv;
      inv = 8'h00;
      for (int i = 1; i < 256; i++) begin
         if (gmul(x, i[7:0]) == 8'h01) inv = i[7:0];
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
             {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   // Behavioural masked S-box: L register stages, result on the last stage.
   logic [15:0] sb_pipe [L];
   always @(posedge clk) begin
      sb_pipe[0] <= {bus.SboxInxDO[15:8] ^ 8'hA5,
                     aes_sbox(bus.SboxInxDO[7:0] ^ bus.SboxInxDO[15:8]) ^ bus.SboxInxDO[15:8] ^ 8'hA5};
      for (int i = 1; i < L; i++) sb_pipe[i] <= sb_pipe[i-1];
   end
   assign bus.SboxOutxDI = sb_pipe[L-1];

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One operation starting in the current cycle (cycle 0). Bubbles on cycles b_lo..b_hi,
   // an extra start pulse with state alt on cycle pulse_c (-1 for none).
   task automatic run_op(input logic [255:0] st, input int b_lo, input int b_hi,
                         input int pulse_c, input logic [255:0] alt);
      logic [127:0] unm, tgt, cur;
      logic [15:0]  exp_in;
      int iss_cyc [16];
      int issued, nb, done_exp, idx;
      logic exp_issue;
      unm = st[127:0] ^ st[255:128];
      for (int k = 0; k < 16; k++) tgt[8*k +: 8] = aes_sbox(unm[8*k +: 8]);
      nb = (b_hi >= b_lo) ? (b_hi - b_lo + 1) : 0;
      done_exp = 17 + L + nb;
      issued = 0;
      for (int c = 0; c <= done_exp + 1; c++) begin
         if (c > 0) tick();
         bus.StartxSI    = (c == 0) || (c == pulse_c);
         bus.StatexDI    = (c == pulse_c) ? alt : st;
         bus.RndValidxSI = !(c >= b_lo && c <= b_hi);
         #1;
         exp_issue = (c >= 1) && (issued < 16) && bus.RndValidxSI;
         chk("rnd_ready", bus.RndReadyxSO, exp_issue);
         chk("busy", bus.BusyxSO, (c >= 1) && (c < done_exp));
         chk("done", bus.DonexSO, c == done_exp);
         if (c >= 1 && c < done_exp) begin
            idx = (issued > 15) ? 15 : issued;
            exp_in = {st[128 + 8*idx +: 8], st[8*idx +: 8]};
`ifdef SUBBYTES_IDLE_ZERO_EN
            if (!exp_issue) exp_in = 16'h0000;
`endif
            chk("sbox_in", bus.SboxInxDO, exp_in);
         end
         for (int k = 0; k < 16; k++)
            cur[8*k +: 8] = (k < issued && iss_cyc[k] + L < c) ? tgt[8*k +: 8] : exp_res[8*k +: 8];
         chk("state_xor", bus.StatexDO[127:0] ^ bus.StatexDO[255:128], cur);
         if (exp_issue) begin
            iss_cyc[issued] = c;
            issued++;
         end
      end
      bus.StartxSI = 1'b0;
      exp_res = tgt;
      // Shares are written back separately: share1 carries the S-box re-sharing mask.
      chk("share1", bus.StatexDO[255:128], st[255:128] ^ {16{8'hA5}});
   endtask

   logic [127:0] r, m, u;
   logic [255:0] st_a, st_b, st_alt;

   initial begin
      checks = 0;
      errors = 0;
      exp_res = '0;
      rst_n = 1'b0;
      bus.StartxSI = 1'b0;
      bus.StatexDI = '0;
      bus.RndValidxSI = 1'b1;
      for (int i = 0; i < L; i++) sb_pipe[i] = 16'h0000;
      tick();
      tick();
      #1;
      chk("rst_busy", bus.BusyxSO, 1'b0);
      chk("rst_done", bus.DonexSO, 1'b0);
      chk("rst_state", bus.StatexDO, '0);
      chk("rst_ready", bus.RndReadyxSO, 1'b0);
      chk("rst_sbox_in", bus.SboxInxDO, '0);
      rst_n = 1'b1;

      // Zero state split as R / R: every result byte combines to 0x63.
      r = {$urandom, $urandom, $urandom, $urandom};
      st_a = {r, r};
      tick();
      run_op(st_a, -1, -2, -1, '0);
      chk("zero_state_63", bus.StatexDO[127:0] ^ bus.StatexDO[255:128], {16{8'h63}});

      // Bytes 0x00,0x01,0x53 in positions 0..2, random elsewhere, randomly split.
      u = {$urandom, $urandom, $urandom, $urandom};
      u[23:0] = 24'h530100;
      m = {$urandom, $urandom, $urandom, $urandom};
      st_b = {m, u ^ m};
      tick();
      run_op(st_b, -1, -2, -1, '0);
      chk("byte0_63", bus.StatexDO[7:0] ^ bus.StatexDO[135:128], 8'h63);
      chk("byte1_7c", bus.StatexDO[15:8] ^ bus.StatexDO[143:136], 8'h7C);
      chk("byte2_ed", bus.StatexDO[23:16] ^ bus.StatexDO[151:144], 8'hED);

      // Randomness missing in cycles 3..5: done moves to cycle 24, same result.
      tick();
      run_op(st_b, 3, 5, -1, '0);
      chk("bubble_byte2_ed", bus.StatexDO[23:16] ^ bus.StatexDO[151:144], 8'hED);

      // Second start at cycle 8 with a different state must be ignored.
      m = {$urandom, $urandom, $urandom, $urandom};
      st_b = {m, u ^ m};
      st_alt = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      tick();
      run_op(st_b, -1, -2, 8, st_alt);
      chk("ignored_start_byte1", bus.StatexDO[15:8] ^ bus.StatexDO[143:136], 8'h7C);

      // Reset in cycle 10 of an operation, restart in cycle 12.
      tick();
      bus.StatexDI = st_a;
      bus.StartxSI = 1'b1;
      for (int c = 1; c <= 11; c++) begin
         tick();
         bus.StartxSI = 1'b0;
         rst_n = (c != 10);
         if (c == 9) begin
            #1;
            chk("mid_busy", bus.BusyxSO, 1'b1);
         end
      end
      #1;
      chk("post_rst_busy", bus.BusyxSO, 1'b0);
      chk("post_rst_done", bus.DonexSO, 1'b0);
      chk("post_rst_state", bus.StatexDO, '0);
      chk("post_rst_ready", bus.RndReadyxSO, 1'b0);
      exp_res = '0;
      tick();
      run_op(st_b, -1, -2, -1, '0);
      chk("restart_byte2_ed", bus.StatexDO[23:16] ^ bus.StatexDO[151:144], 8'hED);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/masked_subbytes_ctrl.md
# masked_subbytes_ctrl

Sequencing controller that applies the masked, pipelined AES S-box to all 16 bytes of a SHARES-way shared AES state. It sits directly upstream and downstream of one S-box instance: it issues one shared byte per cycle into the S-box input, tracks in-flight bytes with a tag pipeline matched to S-box latency, and writes each returning shared byte back into a shared output state. The randomness source feeds the S-box RandomZ/RandomB ports directly; this block only gates its consumption.

## Interface
- SHARES, 2, number of Boolean shares; must match the S-box instance.
- SBOX_LATENCY, 4, cycles from a byte presented on SboxInxDO to its result on SboxOutxDI; ≥1.

- ClkxCI  in  1  clock, rising edge.
- RstxBI  in  1  reset; one clock; reset is synchronous and active-low.
- StartxSI  in  1  start request; sampled only in IDLE.
- StatexDI  in  128*SHARES  input state; share i at [128i+:128], byte k of a share at [8k+:8].
- BusyxSO  out  1  high from the cycle after accepted start until DonexSO.
- DonexSO  out  1  single-cycle completion pulse.
- StatexDO  out  128*SHARES  result state, same layout as StatexDI; registered.
- RndValidxSI  in  1  fresh S-box randomness present this cycle.
- RndReadyxSO  out  1  randomness consumed this cycle (equals issue strobe).
- SboxInxDO  out  8*SHARES  to S-box _XxDI; share i at [8i+:8].
- SboxOutxDI  in  8*SHARES  from S-box _QxDO; same layout.

## Operation
- FSM states: IDLE, FEED, DRAIN, DONE.
- IDLE: StartxSI=1 → latch StatexDI into input register, clear issue/collect counters and tag pipe, go FEED.
- FEED: issue = RndValidxSI. On issue: SboxInxDO = byte[issue_cnt] of every share, RndReadyxSO=1, tag pipe stage 0 ← 1, issue_cnt++. No issue → tag stage 0 ← 0 (bubble). Issue of byte 15 → DRAIN.
- Tag pipe: SBOX_LATENCY-bit shift register, shifts every cycle in FEED and DRAIN. Tag at output stage = 1 → capture SboxOutxDI into byte[collect_cnt] of all shares of StatexDO, collect_cnt++.
- DRAIN: no issue, RndReadyxSO=0; capture of byte 15 → DONE.
- DONE: DonexSO=1 for one cycle, BusyxSO=0, → IDLE. StatexDO holds until next capture.
- Counters 4 bits, bytes in ascending order 0..15; no wrap beyond 15 (FSM exits first).
- StartxSI outside IDLE is ignored; no queuing.
- Shares are never XOR-combined inside this block.
- Reset (any state, including mid-operation): state IDLE, counters 0, tag pipe 0, input register 0, StatexDO 0, all outputs 0. Results still inside the S-box after reset are never captured (tags cleared).

## Timing
- Cycle t = period after clock edge t; StartxSI high in cycle 0 while IDLE.
- FEED from cycle 1; with RndValidxSI constant 1, byte k issued in cycle 1+k, captured at end of cycle 1+k+SBOX_LATENCY.
- Last capture in cycle 16+SBOX_LATENCY; DonexSO high in cycle 17+SBOX_LATENCY (21 for default); BusyxSO high cycles 1..16+SBOX_LATENCY.
- Each cycle of RndValidxSI=0 in FEED delays completion by one cycle.
- RndReadyxSO, SboxInxDO: combinational from state, counters, RndValidxSI. All other outputs registered.
- Earliest next start: cycle after DonexSO.

## Configuration
- SUBBYTES_IDLE_ZERO_EN defined: SboxInxDO driven all-zero on every non-issue cycle (IDLE, bubbles, DRAIN, DONE), preventing stale share data re-entering the S-box.
- Not defined: SboxInxDO presents byte[issue_cnt] (clamped at 15) whenever not issuing; lower mux cost. Captured results are identical in both builds.

## Test plan
- SHARES=2, share0 random R, share1 = R (state 0), RndValidxSI=1, start cycle 0 → DonexSO cycle 21, share0^share1 of every byte = 0x63.
- Byte k of unmasked state = {0x00,0x01,0x53,...} randomly split → result bytes 0x63,0x7C,0xED in positions 0,1,2; ascending capture order confirmed.
- RndValidxSI low cycles 3-5 → RndReadyxSO low those cycles, no tag inserted, DonexSO cycle 24, results unchanged.
- StartxSI pulsed at cycle 8 with different StatexDI → ignored; result reflects cycle-0 state.
- RstxBI low in cycle 10 → next cycle IDLE, BusyxSO=0, StatexDO=0; restart at cycle 12 → no stale capture, correct result, DonexSO at cycle 12+21.
- With SUBBYTES_IDLE_ZERO_EN: SboxInxDO = 0 during bubbles and DRAIN; without: equals byte[issue_cnt]; StatexDO identical in both builds.
